// File: rtl/receiver.sv
// receiver: receiving end of the four-phase Request/Ack word link.
// Captures DEPTH consecutive words into a local buffer and keeps a running
// mod-2^DATA_WIDTH checksum. The finished block is then read out through a
// registered read port. No further words are accepted until the consumer
// pulses Release.
//
// Ports
//   clk        : clock, rising edge
//   Reset      : asynchronous, active-high reset
//   Request    : sender request, DataIn valid while high
//   DataIn     : word from sender
//   Ack        : registered acknowledge to sender
//   WordCount  : words stored in the current block (0 when FULL)
//   BlockValid : buffer holds a complete block
//   Checksum   : running sum of block words, final when BlockValid=1
//   RdAddr     : consumer read address
//   RdData     : mem[RdAddr], registered, 1-cycle latency
//   Release    : single-cycle pulse, frees the buffer
module receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Request,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  Ack,
  output logic [ADDR_WIDTH-1:0] WordCount,
  output logic                  BlockValid,
  output logic [DATA_WIDTH-1:0] Checksum,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  output logic [DATA_WIDTH-1:0] RdData,
  input  logic                  Release
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_HOLD = 2'd1,
    FULL     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    bv_q, bv_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    wr_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      bv_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      bv_q    <= bv_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    bv_d    = bv_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (Request) begin
          wr_en   = 1'b1;
          sum_d   = sum_q + DataIn;
          ack_d   = 1'b1;
          state_d = ACK_HOLD;
        end
      end
      ACK_HOLD: begin
        // Word already captured on entry; wait for Request to fall.
        if (!Request) begin
          ack_d = 1'b0;
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            cnt_d   = '0;
            bv_d    = 1'b1;
            state_d = FULL;
          end else begin
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            state_d = IDLE;
          end
        end
      end
      FULL: begin
        // Request is left pending; it is acked from IDLE after Release.
        ack_d = 1'b0;
        if (Release) begin
          bv_d    = 1'b0;
          sum_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // Buffer memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q] <= DataIn;
  end

  // Read-before-write: a same-cycle write to RdAddr returns the old word.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) rd_q <= '0;
    else       rd_q <= mem[RdAddr];
  end

  assign Ack        = ack_q;
  assign BlockValid = bv_q;
  assign WordCount  = cnt_q;
  assign Checksum   = sum_q;
  assign RdData     = rd_q;

endmodule
